// File: rtl/adc_avg_filter.sv
// Power-of-two moving average over ADC receiver samples, with a registered
// average output, a valid pulse once the window is full, and a deadband change tick.
module adc_avg_filter #(
  parameter int unsigned DW            = 12,
  parameter int unsigned LOG2_DEPTH    = 3,
  parameter int unsigned DEADBAND      = 4,
  parameter int unsigned DISCARD_FIRST = 1
) (
  input  logic                  sclk,
  input  logic                  rst,
  input  logic                  rx_done_tick,
  input  logic [DW-1:0]         adc_data,
  input  logic                  enable,
  input  logic                  clear,
  output logic [DW-1:0]         avg_out,
  output logic                  avg_valid,
  output logic                  filled,
  output logic                  change_tick,
  output logic [LOG2_DEPTH:0]   sample_cnt
);

  localparam int unsigned DEPTH = 1 << LOG2_DEPTH;
  localparam int unsigned AW    = DW + LOG2_DEPTH;
  localparam int unsigned CW    = LOG2_DEPTH + 1;
  localparam int unsigned DW1   = DW + 1;

  logic [DW-1:0]         ring_mem [DEPTH];
  logic [LOG2_DEPTH-1:0] wr_ptr;
  logic [AW-1:0]         acc;
  logic [DW-1:0]         last_reported;
  logic                  first_seen;
  logic                  reported;
  logic                  upd_pend;

  logic                  cap_c;
  logic                  discard_c;
  logic                  write_c;
  logic [DW-1:0]         old_c;
  logic [AW-1:0]         acc_next_c;
  logic [CW-1:0]         cnt_next_c;
  logic [DW-1:0]         avg_new_c;
  logic [DW:0]           diff_c;
  logic                  exceed_c;

  // Capture qualification, evicted-sample lookup and deadband compare
  always_comb begin
    cap_c      = rx_done_tick & enable & ~clear;
    discard_c  = cap_c & (DISCARD_FIRST != 0) & ~first_seen;
    write_c    = cap_c & ~discard_c;
    old_c      = filled ? ring_mem[wr_ptr] : '0;
    acc_next_c = acc + AW'(adc_data) - AW'(old_c);
    cnt_next_c = (sample_cnt == CW'(DEPTH)) ? sample_cnt : sample_cnt + 1'b1;
    avg_new_c  = DW'(acc >> LOG2_DEPTH);
    if ({1'b0, avg_new_c} >= {1'b0, last_reported})
      diff_c = {1'b0, avg_new_c} - {1'b0, last_reported};
    else
      diff_c = {1'b0, last_reported} - {1'b0, avg_new_c};
    exceed_c = diff_c > DW1'(DEADBAND);
  end

  // Sample storage; never read before written, so no reset needed
  always_ff @(posedge sclk) begin
    if (write_c)
      ring_mem[wr_ptr] <= adc_data;
  end

  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      avg_out       <= '0;
      avg_valid     <= 1'b0;
      change_tick   <= 1'b0;
      filled        <= 1'b0;
      sample_cnt    <= '0;
      wr_ptr        <= '0;
      acc           <= '0;
      last_reported <= '0;
      first_seen    <= 1'b0;
      reported      <= 1'b0;
      upd_pend      <= 1'b0;
    end else if (clear) begin
      avg_out       <= '0;
      avg_valid     <= 1'b0;
      change_tick   <= 1'b0;
      filled        <= 1'b0;
      sample_cnt    <= '0;
      wr_ptr        <= '0;
      acc           <= '0;
      last_reported <= '0;
      first_seen    <= 1'b0;
      reported      <= 1'b0;
      upd_pend      <= 1'b0;
    end else begin
      avg_valid   <= 1'b0;
      change_tick <= 1'b0;
      upd_pend    <= write_c;
      if (discard_c)
        first_seen <= 1'b1;
      if (write_c) begin
        acc        <= acc_next_c;
        wr_ptr     <= wr_ptr + 1'b1;
        sample_cnt <= cnt_next_c;
        filled     <= (cnt_next_c == CW'(DEPTH));
      end
      // Output stage sees the accumulator as left by the previous capture
      if (upd_pend && filled) begin
        avg_out   <= avg_new_c;
        avg_valid <= 1'b1;
        if (!reported || exceed_c) begin
          change_tick   <= 1'b1;
          last_reported <= avg_new_c;
          reported      <= 1'b1;
        end
      end
    end
  end

endmodule
